// File: rtl/myo_spi_responder.sv
// SPI mode-0 responder for the myocontrol bus: oversamples sck/mosi/ss_n in the
// system clock domain, deserialises master words and serialises loaded responder words.
`timescale 1ns/1ps

module myo_spi_responder #(
    parameter int WORD_WIDTH  = 16,
    parameter int MAX_WORDS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sck,
    input  logic                             mosi,
    input  logic                             ss_n,
    output logic                             miso,
    output logic                             miso_oe,
    output logic [WORD_WIDTH-1:0]            rx_data,
    output logic                             rx_valid,
    output logic [$clog2(MAX_WORDS)-1:0]     rx_word_index,
    input  logic [WORD_WIDTH-1:0]            tx_data,
    output logic                             tx_load,
    output logic                             frame_active,
    output logic                             frame_done,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_word_count,
    output logic                             frame_error
);

    localparam int BIT_W = $clog2(WORD_WIDTH + 1);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SHIFT   = 2'd2,
        OVERRUN = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
    logic [SYNC_STAGES:0]   sync_vld_q;
    logic                   sck_last_q, ss_last_q;
    logic                   sck_s, mosi_s, ss_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    state_t                 state_q, state_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [WORD_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [WORD_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic                   end_pend_q, end_pend_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   frame_active_q, frame_active_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [WORD_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [IDX_W-1:0]       rx_idx_q, rx_idx_d;
    logic                   frame_done_q, frame_done_d;
    logic [CNT_W-1:0]       frame_count_q, frame_count_d;
    logic                   frame_error_q, frame_error_d;

    logic                   ending, completing, finish, finish_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sync_vld_q  <= '0;
            sck_last_q  <= 1'b0;
            ss_last_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            sync_vld_q  <= {sync_vld_q[SYNC_STAGES-1:0], 1'b1};
            sck_last_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_last_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_last_q;
    assign sck_fall = ~sck_s & sck_last_q;
    assign ss_fall  = ~ss_s & ss_last_q;
    assign ss_rise  = ss_s & ~ss_last_q;

    // NOTE: every combinational output gets a default before the case so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        word_cnt_d     = word_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        end_pend_d     = end_pend_q;
        miso_d         = miso_q;
        miso_oe_d      = miso_oe_q;
        frame_active_d = frame_active_q;
        rx_data_d      = rx_data_q;
        rx_idx_d       = rx_idx_q;
        frame_count_d  = frame_count_q;
        rx_valid_d     = 1'b0;
        frame_done_d   = 1'b0;
        frame_error_d  = 1'b0;
        tx_load        = 1'b0;
        ending         = 1'b0;
        completing     = 1'b0;
        finish         = 1'b0;
        finish_err     = 1'b0;

        case (state_q)
            IDLE: begin
                // The synchroniser reset value reads as "deselected"; only arm once
                // the pipeline holds a genuinely sampled high ss_n.
                if (sync_vld_q[SYNC_STAGES] && ss_s && ss_last_q) begin
                    state_d = ARMED;
                end
            end

            ARMED: begin
                if (ss_fall) begin
                    tx_load        = 1'b1;
                    tx_shift_d     = tx_data;
                    miso_d         = tx_data[WORD_WIDTH-1];
                    bit_cnt_d      = '0;
                    word_cnt_d     = '0;
                    end_pend_d     = 1'b0;
                    frame_active_d = 1'b1;
                    miso_oe_d      = 1'b1;
                    state_d        = SHIFT;
                end
            end

            SHIFT: begin
                ending     = ss_rise | end_pend_q;
                completing = sck_rise && (bit_cnt_q == BIT_LAST);

                if (sck_rise && (bit_cnt_q != BIT_FULL)) begin
                    rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (completing) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {rx_shift_q[WORD_WIDTH-2:0], mosi_s};
                        rx_idx_d   = word_cnt_q[IDX_W-1:0];
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else if (sck_fall && (bit_cnt_q != '0) && (bit_cnt_q != BIT_FULL)) begin
                    tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
                    miso_d     = tx_shift_q[WORD_WIDTH-2];
                end

                // Word just completed: reload for the next word unless the frame is
                // closing or the word budget is spent.
                if (bit_cnt_q == BIT_FULL) begin
                    bit_cnt_d = '0;
                    if (!ending) begin
                        if (word_cnt_q < CNT_MAX) begin
                            tx_load    = 1'b1;
                            tx_shift_d = tx_data;
                            miso_d     = tx_data[WORD_WIDTH-1];
                        end else begin
                            miso_d  = 1'b0;
                            state_d = OVERRUN;
                        end
                    end
                end

                if (ending) begin
                    if (completing) begin
                        end_pend_d = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        finish_err = (bit_cnt_q != '0) && (bit_cnt_q != BIT_FULL);
                    end
                end
            end

            OVERRUN: begin
                if (ss_rise) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (finish) begin
            frame_done_d   = 1'b1;
            frame_count_d  = word_cnt_q;
            frame_error_d  = finish_err;
            frame_active_d = 1'b0;
            miso_oe_d      = 1'b0;
            miso_d         = 1'b0;
            bit_cnt_d      = '0;
            end_pend_d     = 1'b0;
            state_d        = ARMED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            word_cnt_q     <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            end_pend_q     <= 1'b0;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
            frame_active_q <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_idx_q       <= '0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= '0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            word_cnt_q     <= word_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            end_pend_q     <= end_pend_d;
            miso_q         <= miso_d;
            miso_oe_q      <= miso_oe_d;
            frame_active_q <= frame_active_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            rx_idx_q       <= rx_idx_d;
            frame_done_q   <= frame_done_d;
            frame_count_q  <= frame_count_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign miso             = miso_q;
    assign miso_oe          = miso_oe_q;
    assign frame_active     = frame_active_q;
    assign rx_valid         = rx_valid_q;
    assign rx_data          = rx_data_q;
    assign rx_word_index    = rx_idx_q;
    assign frame_done       = frame_done_q;
    assign frame_word_count = frame_count_q;
    assign frame_error      = frame_error_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Bench for myo_spi_responder: a mode-0 SPI master model drives a table of frames,
// a scoreboard checks received words and frame reports, plus reset/coincidence cases.
`timescale 1ns/1ps

module tb_myo_spi_responder;

    localparam int W     = 16;
    localparam int MAXW  = 12;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck, mosi, ss_n;
    logic        miso, miso_oe;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [3:0]  rx_word_index;
    logic [15:0] tx_data;
    logic        tx_load;
    logic        frame_active, frame_done;
    logic [3:0]  frame_word_count;
    logic        frame_error;

    myo_spi_responder #(.WORD_WIDTH(W), .MAX_WORDS(MAXW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_word_index(rx_word_index), .tx_data(tx_data), .tx_load(tx_load),
        .frame_active(frame_active), .frame_done(frame_done),
        .frame_word_count(frame_word_count), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  idx;
    } rx_exp_t;

    typedef struct {
        int count;
        bit err;
    } fr_exp_t;

    typedef struct {
        int          full_words;
        int          extra_bits;
        bit          coincident;
        logic [15:0] rx0;
        logic [15:0] tx_base;
        logic [15:0] tx_step;
        int          exp_count;
        bit          exp_err;
        int          exp_loads;
    } vec_t;

    rx_exp_t rx_q[$];
    fr_exp_t fr_q[$];
    rx_exp_t rx_e;
    fr_exp_t fr_e;

    int total = 0;
    int bad   = 0;
    int n_rx = 0, n_done = 0, n_load = 0;
    int last_rx_cyc = 0, last_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every DUT report is matched against queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_load) n_load++;
            if (rx_valid) begin
                n_rx++;
                last_rx_cyc = cyc;
                if (rx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got word %h idx %0d, want no rx_valid", rx_data, rx_word_index);
                end else begin
                    rx_e = rx_q.pop_front();
                    check("rx_data", rx_data, rx_e.data);
                    check("rx_index", rx_word_index, rx_e.idx);
                end
            end
            if (frame_done) begin
                n_done++;
                last_done_cyc = cyc;
                if (fr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got frame_done count %0d, want none", frame_word_count);
                end else begin
                    fr_e = fr_q.pop_front();
                    check("frame_count", frame_word_count, fr_e.count);
                    check("frame_error", frame_error, fr_e.err);
                    check("frame_active_at_done", frame_active, 1'b0);
                    check("rx_missing", rx_q.size(), 0);
                end
            end else if (frame_error) begin
                total++;
                bad++;
                $display("FAIL error_without_done: got frame_error=1, want 0");
            end
        end
    end

    function automatic logic [15:0] mword(input vec_t v, input int j);
        return v.rx0 + 16'(j) * 16'h1111;
    endfunction

    function automatic logic [15:0] txw(input vec_t v, input int j);
        return v.tx_base + 16'(j) * v.tx_step;
    endfunction

    task automatic run_frame(input vec_t v);
        int words, nb, done0, load0, rise_cyc;
        logic [15:0] mw, rd, exp_rd;
        bit got;
        words = v.full_words + ((v.extra_bits > 0) ? 1 : 0);
        for (int j = 0; j < v.full_words && j < MAXW; j++)
            rx_q.push_back('{data: mword(v, j), idx: 4'(j)});
        fr_q.push_back('{count: v.exp_count, err: v.exp_err});
        done0 = n_done;
        load0 = n_load;
        rise_cyc = 0;
        tx_data = txw(v, 0);
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("frame_active_start", frame_active, 1'b1);
        check("miso_oe_start", miso_oe, 1'b1);
        for (int j = 0; j < words; j++) begin
            nb = (j < v.full_words) ? W : v.extra_bits;
            mw = mword(v, j);
            rd = '0;
            for (int b = 0; b < nb; b++) begin
                mosi = mw[15-b];
                repeat (2) @(negedge clk);
                rd = {rd[14:0], miso};
                if (v.coincident && j == words - 1 && b == nb - 1) ss_n = 1'b1;
                sck = 1'b1;
                rise_cyc = cyc;
                repeat (HALF) @(negedge clk);
                sck = 1'b0;
                if (b == 0) tx_data = txw(v, j + 1);
                repeat (HALF - 2) @(negedge clk);
            end
            exp_rd = (j >= MAXW) ? 16'h0000 : (txw(v, j) >> (W - nb));
            check("miso_word", rd, exp_rd);
            if (nb == W && j < MAXW) check("rx_latency", last_rx_cyc - rise_cyc, SYNC + 1);
        end
        if (!v.coincident) begin
            repeat (2) @(negedge clk);
            ss_n = 1'b1;
        end
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = (n_done != done0);
        end
        check("frame_done_seen", got, 1'b1);
        check("tx_load_count", n_load - load0, v.exp_loads);
        if (v.coincident) check("done_after_rx", last_done_cyc - last_rx_cyc, 1);
        repeat (HALF) @(negedge clk);
        check("miso_oe_idle", miso_oe, 1'b0);
        check("count_held", frame_word_count, v.exp_count);
    endtask

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx0, done0;
        vecs[0] = '{1,  0, 1'b0, 16'hA5C3, 16'h1234, 16'h0000, 1,  1'b0, 2};
        vecs[1] = '{3,  0, 1'b0, 16'h0F1E, 16'h1111, 16'h1111, 3,  1'b0, 4};
        vecs[2] = '{2,  9, 1'b0, 16'hC0DE, 16'hABCD, 16'h0101, 2,  1'b1, 3};
        vecs[3] = '{13, 0, 1'b0, 16'h8001, 16'h0100, 16'h0001, 12, 1'b1, 12};
        vecs[4] = '{0,  0, 1'b0, 16'h0000, 16'h4321, 16'h0000, 0,  1'b0, 1};
        vecs[5] = '{1,  0, 1'b1, 16'h5AA5, 16'h7E81, 16'h0000, 1,  1'b0, 1};

        reset = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1; tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_miso", miso, 1'b0);
        check("reset_miso_oe", miso_oe, 1'b0);
        check("reset_tx_load", tx_load, 1'b0);
        check("reset_frame_active", frame_active, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset in the middle of a word, released while the master keeps ss_n low.
        rx0 = n_rx;
        done0 = n_done;
        tx_data = 16'hDEAD;
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            mosi = b[0];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_rx_data", rx_data, 16'h0000);
        check("midreset_count", frame_word_count, 4'd0);
        check("midreset_miso_oe", miso_oe, 1'b0);
        check("midreset_frame_active", frame_active, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int b = 0; b < 2 * W; b++) begin
            mosi = b[1];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        check("midreset_miso_oe_ignored", miso_oe, 1'b0);
        ss_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_no_rx", n_rx - rx0, 0);
        check("midreset_no_done", n_done - done0, 0);

        run_frame(vecs[0]);
        run_frame(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
